// File: rtl/jesd_tx_pkg.sv
// Shared encodings and types for the JESD204B TX lane octet path.
// Holds mux selections, control characters, ILA states and the cfg/FCHK bundle.
package jesd_tx_pkg;

    localparam logic [2:0] SEND_USER_DATA = 3'd0;
    localparam logic [2:0] SEND_K         = 3'd1;
    localparam logic [2:0] SEND_LANE_SEQ  = 3'd2;

    localparam logic [7:0] K_28_5 = 8'hBC;
    localparam logic [7:0] K_28_0 = 8'h1C;
    localparam logic [7:0] K_28_3 = 8'h7C;
    localparam logic [7:0] K_28_4 = 8'h9C;

    localparam int CFG_OCTETS = 13;

    typedef enum logic {
        ILA_WAIT = 1'b0,
        ILA_RUN  = 1'b1
    } ila_state_t;

    typedef struct packed {
        logic [CFG_OCTETS-1:0][7:0] octets;
        logic [7:0]                 fchk;
    } ila_cfg_t;

    // 8-bit wrapping sum of the config octets
    function automatic logic [7:0] calc_fchk(input logic [CFG_OCTETS-1:0][7:0] octets);
        logic [7:0] sum;
        sum = '0;
        for (int i = 0; i < CFG_OCTETS; i++) begin
            sum = sum + octets[i];
        end
        return sum;
    endfunction

endpackage

// File: rtl/tx_lane_octet_mux_ila_octet_gen.sv
// ILA octet map: /R/ first, /A/ last, /Q/ + cfg + FCHK in multiframe 1, ramp elsewhere.
// Purely combinational, no flow control.
module ila_octet_gen
    import jesd_tx_pkg::*;
#(
    parameter int F = 2,
    parameter int K = 16
) (
    input  logic [$clog2(F*K)-1:0] oct_cnt,
    input  logic [7:0]             mf_idx,
    input  ila_cfg_t               cfg,
    output logic [7:0]             octet,
    output logic                   is_k
);

    localparam int CW = $clog2(F*K);
    localparam logic [CW-1:0] N_LAST      = CW'(F*K-1);
    localparam logic [CW-1:0] N_Q         = CW'(1);
    localparam logic [CW-1:0] N_CFG_FIRST = CW'(2);
    localparam logic [CW-1:0] N_CFG_LAST  = CW'(14);
    localparam logic [CW-1:0] N_FCHK      = CW'(15);

    logic [3:0] cfg_sel;
    assign cfg_sel = 4'(oct_cnt - N_CFG_FIRST);

    always_comb begin
        octet = 8'(oct_cnt);
        is_k  = 1'b0;
        if (oct_cnt == '0) begin
            octet = K_28_0;
            is_k  = 1'b1;
        end else if (oct_cnt == N_LAST) begin
            octet = K_28_3;
            is_k  = 1'b1;
        end else if (mf_idx == 8'd1) begin
            // oct_cnt 0 and 1 are already excluded, so only the upper bound matters here
            if (oct_cnt == N_Q) begin
                octet = K_28_4;
                is_k  = 1'b1;
            end else if (oct_cnt <= N_CFG_LAST) begin
                octet = cfg.octets[cfg_sel];
            end else if (oct_cnt == N_FCHK) begin
                octet = cfg.fchk;
            end
        end
    end

endmodule

// File: rtl/tx_lane_octet_mux.sv
// Lane octet source: user data, K28.5 fill or LMFC-aligned ILA, one registered octet per clk.
// Latency 1 cycle; no backpressure, the encoder consumes every cycle.
module tx_lane_octet_mux
    import jesd_tx_pkg::*;
#(
    parameter int F = 2,
    parameter int K = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2:0]   i_link_mux,
    input  logic         i_lmfc_clk,
    input  logic [7:0]   i_user_data,
    input  logic [103:0] i_link_cfg,
    output logic [7:0]   o_octet,
    output logic         o_is_k,
    output logic         o_ila_active,
    output logic         o_align_err
);

    localparam int CW = $clog2(F*K);
    localparam logic [CW-1:0] N_LAST = CW'(F*K-1);

    ila_state_t    state_q, state_d;
    logic [CW-1:0] oct_cnt_q, oct_cnt_d, gen_cnt;
    logic [7:0]    mf_idx_q, mf_idx_d;
    ila_cfg_t      cfg_q, cfg_d;
    logic [7:0]    gen_octet, octet_d;
    logic          gen_k, is_k_d, ila_active_d, align_err_d;

    ila_octet_gen #(
        .F (F),
        .K (K)
    ) u_ila_octet_gen (
        .oct_cnt (gen_cnt),
        .mf_idx  (mf_idx_q),
        .cfg     (cfg_q),
        .octet   (gen_octet),
        .is_k    (gen_k)
    );

    always_comb begin
        state_d      = state_q;
        oct_cnt_d    = oct_cnt_q;
        mf_idx_d     = mf_idx_q;
        cfg_d        = cfg_q;
        gen_cnt      = oct_cnt_q;
        octet_d      = K_28_5;
        is_k_d       = 1'b1;
        ila_active_d = 1'b0;
        align_err_d  = 1'b0;

        if (i_link_mux != SEND_LANE_SEQ) begin
            state_d   = ILA_WAIT;
            oct_cnt_d = '0;
            mf_idx_d  = '0;
            if (i_link_mux == SEND_USER_DATA) begin
                octet_d = i_user_data;
                is_k_d  = 1'b0;
            end
        end else if (state_q == ILA_RUN || i_lmfc_clk) begin
            if (state_q == ILA_WAIT) begin
                cfg_d.octets = i_link_cfg;
                cfg_d.fchk   = calc_fchk(i_link_cfg);
            end
            state_d = ILA_RUN;
            // A strobe always marks octet 0; arriving off-boundary means we slipped
            if (i_lmfc_clk) begin
                gen_cnt     = '0;
                align_err_d = (oct_cnt_q != '0);
            end
            octet_d      = gen_octet;
            is_k_d       = gen_k;
            ila_active_d = 1'b1;
            if (gen_cnt == N_LAST) begin
                oct_cnt_d = '0;
                if (mf_idx_q != 8'hFF) begin
                    mf_idx_d = mf_idx_q + 8'd1;
                end
            end else begin
                oct_cnt_d = gen_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ILA_WAIT;
            oct_cnt_q    <= '0;
            mf_idx_q     <= '0;
            cfg_q        <= '0;
            o_octet      <= K_28_5;
            o_is_k       <= 1'b1;
            o_ila_active <= 1'b0;
            o_align_err  <= 1'b0;
        end else begin
            state_q      <= state_d;
            oct_cnt_q    <= oct_cnt_d;
            mf_idx_q     <= mf_idx_d;
            cfg_q        <= cfg_d;
            o_octet      <= octet_d;
            o_is_k       <= is_k_d;
            o_ila_active <= ila_active_d;
            o_align_err  <= align_err_d;
        end
    end

endmodule

// File: tb/tb_tx_lane_octet_mux.sv
// Randomized bench for tx_lane_octet_mux against a behavioural ILA model.
module tb_tx_lane_octet_mux;

    localparam int F      = 2;
    localparam int K      = 16;
    localparam int MF_LEN = F * K;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   i_link_mux = 3'd1;
    logic         i_lmfc_clk = 1'b0;
    logic [7:0]   i_user_data = 8'h00;
    logic [103:0] i_link_cfg = '0;
    logic [7:0]   o_octet;
    logic         o_is_k;
    logic         o_ila_active;
    logic         o_align_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    bit           m_run;
    int           m_n;
    int           m_mf;
    byte unsigned m_cfg [13];
    byte unsigned m_fchk;

    logic [7:0] exp_octet;
    logic       exp_k, exp_act, exp_err;

    tx_lane_octet_mux #(.F(F), .K(K)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_link_mux   (i_link_mux),
        .i_lmfc_clk   (i_lmfc_clk),
        .i_user_data  (i_user_data),
        .i_link_cfg   (i_link_cfg),
        .o_octet      (o_octet),
        .o_is_k       (o_is_k),
        .o_ila_active (o_ila_active),
        .o_align_err  (o_align_err)
    );

    always #5 clk = ~clk;

    task automatic model_ila(input int n, input int mf, output logic [7:0] o, output logic k);
        o = 8'(n);
        k = 1'b0;
        if (n == 0) begin
            o = 8'h1C; k = 1'b1;
        end else if (n == MF_LEN - 1) begin
            o = 8'h7C; k = 1'b1;
        end else if (mf == 1 && n == 1) begin
            o = 8'h9C; k = 1'b1;
        end else if (mf == 1 && n >= 2 && n <= 14) begin
            o = m_cfg[n-2];
        end else if (mf == 1 && n == 15) begin
            o = m_fchk;
        end
    endtask

    // Predicts the octet produced by this edge, advances the model, then waits past the edge.
    task automatic tick();
        int cur;
        int sum;
        exp_octet = 8'hBC;
        exp_k     = 1'b1;
        exp_act   = 1'b0;
        exp_err   = 1'b0;
        if (i_link_mux != 3'd2) begin
            m_run = 0; m_n = 0; m_mf = 0;
            if (i_link_mux == 3'd0) begin
                exp_octet = i_user_data;
                exp_k     = 1'b0;
            end
        end else if (m_run || i_lmfc_clk) begin
            if (!m_run) begin
                m_run = 1; m_n = 0; m_mf = 0;
                sum = 0;
                for (int i = 0; i < 13; i++) begin
                    m_cfg[i] = i_link_cfg[8*i +: 8];
                    sum += int'(m_cfg[i]);
                end
                m_fchk = 8'(sum % 256);
            end
            cur = m_n;
            if (i_lmfc_clk && cur != 0) begin
                cur = 0;
                exp_err = 1'b1;
            end
            model_ila(cur, m_mf, exp_octet, exp_k);
            exp_act = 1'b1;
            cur++;
            if (cur == MF_LEN) begin
                cur = 0;
                if (m_mf < 255) m_mf++;
            end
            m_n = cur;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        m_run = 0; m_n = 0; m_mf = 0;
        rst_n = 1'b0;
        i_link_mux = 3'd1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (o_octet !== 8'hBC || o_is_k !== 1'b1 || o_ila_active !== 1'b0 || o_align_err !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold got=%02h k=%0b act=%0b err=%0b exp=bc k=1 act=0 err=0",
                         o_octet, o_is_k, o_ila_active, o_align_err);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (o_octet !== 8'hBC || o_is_k !== 1'b1 || o_ila_active !== 1'b0 || o_align_err !== 1'b0) begin
                failures++;
                $display("FAIL reset_release got=%02h k=%0b act=%0b err=%0b exp=bc k=1 act=0 err=0",
                         o_octet, o_is_k, o_ila_active, o_align_err);
            end
        end
    endtask

    task automatic test_user_data();
        logic [7:0] seq [2];
        seq[0] = 8'hA5;
        seq[1] = 8'h3C;
        i_link_mux = 3'd0;
        for (int i = 0; i < 2; i++) begin
            i_user_data = seq[i];
            tick();
            checks++;
            if (o_octet !== seq[i] || o_is_k !== 1'b0) begin
                failures++;
                $display("FAIL user_directed got=%02h k=%0b exp=%02h k=0", o_octet, o_is_k, seq[i]);
            end
        end
        for (int i = 0; i < 16; i++) begin
            i_user_data = 8'($urandom);
            i_lmfc_clk  = 1'($urandom);
            tick();
            checks++;
            if (o_octet !== exp_octet || o_is_k !== exp_k || o_ila_active !== 1'b0) begin
                failures++;
                $display("FAIL user_random cyc=%0d got=%02h k=%0b act=%0b exp=%02h k=%0b act=0",
                         cyc, o_octet, o_is_k, o_ila_active, exp_octet, exp_k);
            end
        end
        i_lmfc_clk = 1'b0;
    endtask

    task automatic test_k_modes();
        int v;
        for (int i = 0; i < 24; i++) begin
            v = $urandom_range(0, 5);
            i_link_mux  = (v == 0) ? 3'd1 : 3'(v + 2);
            i_user_data = 8'($urandom);
            i_lmfc_clk  = 1'($urandom);
            tick();
            checks++;
            if (o_octet !== 8'hBC || o_is_k !== 1'b1 || o_ila_active !== 1'b0 || o_align_err !== 1'b0) begin
                failures++;
                $display("FAIL k_mode mux=%0d got=%02h k=%0b act=%0b err=%0b exp=bc k=1 act=0 err=0",
                         i_link_mux, o_octet, o_is_k, o_ila_active, o_align_err);
            end
        end
        i_lmfc_clk = 1'b0;
    endtask

    task automatic test_ila_sequence();
        i_link_mux = 3'd1;
        tick();
        i_link_cfg = 104'({$urandom, $urandom, $urandom, $urandom});
        i_link_mux = 3'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (o_octet !== 8'hBC || o_ila_active !== 1'b0) begin
                failures++;
                $display("FAIL ila_wait got=%02h act=%0b exp=bc act=0", o_octet, o_ila_active);
            end
        end
        for (int i = 0; i < 3 * MF_LEN; i++) begin
            i_lmfc_clk = (i % MF_LEN == 0);
            if (i == 40) i_link_cfg = 104'({$urandom, $urandom, $urandom, $urandom});
            tick();
            checks++;
            if (o_octet !== exp_octet || o_is_k !== exp_k || o_ila_active !== 1'b1 || o_align_err !== 1'b0) begin
                failures++;
                $display("FAIL ila_seq i=%0d got=%02h k=%0b act=%0b err=%0b exp=%02h k=%0b act=1 err=0",
                         i, o_octet, o_is_k, o_ila_active, o_align_err, exp_octet, exp_k);
            end
            if (i == 0 || i == 31 || i == 33 || (i >= 1 && i <= 30)) begin
                checks++;
                if ((i == 0 && o_octet !== 8'h1C) || (i == 31 && o_octet !== 8'h7C) ||
                    (i == 33 && o_octet !== 8'h9C) || (i >= 1 && i <= 30 && o_octet !== 8'(i))) begin
                    failures++;
                    $display("FAIL ila_fixed i=%0d got=%02h", i, o_octet);
                end
            end
        end
        i_lmfc_clk = 1'b0;
    endtask

    task automatic test_checksum();
        logic [7:0] pat [2];
        logic [7:0] want [2];
        pat[0] = 8'h01; want[0] = 8'h0D;
        pat[1] = 8'hFF; want[1] = 8'hF3;
        for (int p = 0; p < 2; p++) begin
            i_link_mux = 3'd1;
            tick();
            i_link_mux = 3'd2;
            i_link_cfg = {13{pat[p]}};
            for (int i = 0; i < MF_LEN + 17; i++) begin
                i_lmfc_clk = (i % MF_LEN == 0);
                if (i == 1) i_link_cfg = 104'({$urandom, $urandom, $urandom, $urandom});
                tick();
                checks++;
                if (o_octet !== exp_octet || o_is_k !== exp_k) begin
                    failures++;
                    $display("FAIL fchk_seq p=%0d i=%0d got=%02h k=%0b exp=%02h k=%0b",
                             p, i, o_octet, o_is_k, exp_octet, exp_k);
                end
                if (i == MF_LEN + 15) begin
                    checks++;
                    if (o_octet !== want[p] || o_is_k !== 1'b0) begin
                        failures++;
                        $display("FAIL fchk_value p=%0d got=%02h k=%0b exp=%02h k=0", p, o_octet, o_is_k, want[p]);
                    end
                end
            end
        end
        i_lmfc_clk = 1'b0;
    endtask

    task automatic test_misalign();
        i_link_mux = 3'd1;
        tick();
        i_link_mux = 3'd2;
        for (int i = 0; i < 40; i++) begin
            i_lmfc_clk = (i == 0 || i == 10);
            tick();
            checks++;
            if (o_octet !== exp_octet || o_is_k !== exp_k || o_align_err !== exp_err || o_ila_active !== exp_act) begin
                failures++;
                $display("FAIL misalign_seq i=%0d got=%02h k=%0b err=%0b exp=%02h k=%0b err=%0b",
                         i, o_octet, o_is_k, o_align_err, exp_octet, exp_k, exp_err);
            end
            if (i == 10 || i == 11) begin
                checks++;
                if ((i == 10 && (o_align_err !== 1'b1 || o_octet !== 8'h1C)) ||
                    (i == 11 && (o_align_err !== 1'b0 || o_octet !== 8'h01))) begin
                    failures++;
                    $display("FAIL misalign_fixed i=%0d got=%02h err=%0b", i, o_octet, o_align_err);
                end
            end
        end
        i_lmfc_clk = 1'b0;
    endtask

    task automatic test_mux_abort();
        i_link_mux = 3'd1;
        tick();
        i_link_mux = 3'd2;
        for (int i = 0; i < 12; i++) begin
            i_lmfc_clk = (i == 0);
            tick();
        end
        i_lmfc_clk = 1'b0;
        for (int i = 0; i < 22; i++) begin
            i_link_mux = (i < 2) ? 3'd1 : 3'd2;
            tick();
            checks++;
            if (o_octet !== 8'hBC || o_is_k !== 1'b1 || o_ila_active !== 1'b0) begin
                failures++;
                $display("FAIL abort_hold i=%0d got=%02h k=%0b act=%0b exp=bc k=1 act=0",
                         i, o_octet, o_is_k, o_ila_active);
            end
        end
        for (int i = 0; i < 2; i++) begin
            i_lmfc_clk = (i == 0);
            tick();
            checks++;
            if (o_octet !== ((i == 0) ? 8'h1C : 8'h01) || o_ila_active !== 1'b1 || o_align_err !== 1'b0) begin
                failures++;
                $display("FAIL abort_restart i=%0d got=%02h act=%0b err=%0b exp=%02h act=1 err=0",
                         i, o_octet, o_ila_active, o_align_err, (i == 0) ? 8'h1C : 8'h01);
            end
        end
        i_lmfc_clk = 1'b0;
    endtask

    task automatic test_saturate();
        int bad;
        bad = 0;
        i_link_mux = 3'd1;
        tick();
        i_link_mux = 3'd2;
        i_link_cfg = 104'({$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 259 * MF_LEN; i++) begin
            i_lmfc_clk = (i % MF_LEN == 0);
            tick();
            checks++;
            if (o_octet !== exp_octet || o_is_k !== exp_k || o_align_err !== 1'b0) begin
                failures++;
                if (bad < 5) $display("FAIL saturate i=%0d got=%02h k=%0b err=%0b exp=%02h k=%0b err=0",
                                      i, o_octet, o_is_k, o_align_err, exp_octet, exp_k);
                bad++;
            end
        end
        i_lmfc_clk = 1'b0;
    endtask

    task automatic test_random();
        int r;
        int phase;
        int bad;
        phase = 0;
        bad = 0;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3) i_link_mux = 3'd0;
            else if (r < 5) i_link_mux = 3'($urandom_range(1, 7));
            else if (r < 10) i_link_mux = (i_link_mux == 3'd2) ? 3'd2 : 3'($urandom_range(0, 2));
            else if (r < 40) i_link_mux = 3'd2;
            i_user_data = 8'($urandom);
            if ($urandom_range(0, 49) == 0) i_link_cfg = 104'({$urandom, $urandom, $urandom, $urandom});
            i_lmfc_clk = (phase % MF_LEN == 0) || ($urandom_range(0, 99) == 0);
            phase++;
            if ($urandom_range(0, 199) == 0) phase = $urandom_range(0, MF_LEN - 1);
            tick();
            checks++;
            if (o_octet !== exp_octet || o_is_k !== exp_k || o_ila_active !== exp_act || o_align_err !== exp_err) begin
                failures++;
                if (bad < 5) $display("FAIL random cyc=%0d got=%02h k=%0b act=%0b err=%0b exp=%02h k=%0b act=%0b err=%0b",
                                      cyc, o_octet, o_is_k, o_ila_active, o_align_err,
                                      exp_octet, exp_k, exp_act, exp_err);
                bad++;
            end
        end
        i_lmfc_clk = 1'b0;
    endtask

    initial begin
        test_reset();
        test_user_data();
        test_k_modes();
        test_ila_sequence();
        test_checksum();
        test_misalign();
        test_mux_abort();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
